// File: rtl/alu_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer_if
//   Command and result handshake bundle for alu_cmd_sequencer.
//   Command channel : cmd_valid/cmd_ready with cmd_op, cmd_a, cmd_b, cmd_acc.
//   Result channel  : res_valid/res_ready with res_data, res_cout, res_zero.
//   modport master : the command producer / result consumer.
//   modport slave  : the sequencer itself.
// ---------------------------------------------------------------------------
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPW-1:0]   cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_acc;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_cout;
    logic             res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, res_ready,
        input  cmd_ready, res_valid, res_data, res_cout, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, res_ready,
        output cmd_ready, res_valid, res_data, res_cout, res_zero
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Upstream command stage for a 16-bit, 2-op-bit ALU
//   (op 00 AND, 01 OR, 10 ADD, 11 SUB).
//   A command is accepted in IDLE, its operands are registered towards the
//   ALU, the ALU's combinational result is captured one cycle later (EXEC),
//   and the result is offered on the result handshake (DONE) until taken.
//   A running accumulator holds the last captured result and can replace
//   operand A.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset; aborts any command in flight
//   bus       : alu_cmd_sequencer_if.slave (command + result handshakes)
//   alu_op    : registered op-code to the ALU
//   alu_i0    : registered operand A to the ALU
//   alu_i1    : registered operand B to the ALU
//   alu_o     : ALU result (combinational from alu_*)
//   alu_cout  : ALU carry-out
//   acc_q     : accumulator value
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int WIDTH = 16,
    parameter int OPW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_sequencer_if.slave bus,
    output logic [OPW-1:0]    alu_op,
    output logic [WIDTH-1:0]  alu_i0,
    output logic [WIDTH-1:0]  alu_i1,
    input  logic [WIDTH-1:0]  alu_o,
    input  logic              alu_cout,
    output logic [WIDTH-1:0]  acc_q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;

    logic             cmd_ready_r;
    logic             res_valid_r;
    logic [OPW-1:0]   alu_op_r;
    logic [WIDTH-1:0] alu_i0_r;
    logic [WIDTH-1:0] alu_i1_r;
    logic [WIDTH-1:0] res_data_r;
    logic             res_cout_r;
    logic             res_zero_r;
    logic [WIDTH-1:0] acc_r;

    // Zero detect on a result word.
    function automatic logic is_zero(input logic [WIDTH-1:0] value);
        return (value == {WIDTH{1'b0}});
    endfunction

    // Carry is meaningful only for the arithmetic ops (op MSB set: ADD/SUB);
    // logic ops report no carry regardless of what the ALU drives.
    function automatic logic carry_for_op(input logic [OPW-1:0] op, input logic carry);
        return op[OPW-1] ? carry : 1'b0;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and command accept strobe.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_DONE;
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Handshake flags registered from the next state so they track the FSM
    // exactly while still coming straight out of flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
        end else begin
            cmd_ready_r <= (state_next_s == ST_IDLE);
            res_valid_r <= (state_next_s == ST_DONE);
        end
    end

    // ALU operand registers: load only on an IDLE accept, otherwise hold.
    // Operand A takes the accumulator when requested; acc_r only moves in
    // EXEC, so here it always holds the previous command's result.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_r <= {OPW{1'b0}};
            alu_i0_r <= {WIDTH{1'b0}};
            alu_i1_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            alu_op_r <= bus.cmd_op;
            alu_i0_r <= bus.cmd_acc ? acc_r : bus.cmd_a;
            alu_i1_r <= bus.cmd_b;
        end else begin
            alu_op_r <= alu_op_r;
            alu_i0_r <= alu_i0_r;
            alu_i1_r <= alu_i1_r;
        end
    end

    // Result capture and accumulator update at the end of EXEC; the values
    // then stay frozen through DONE until the next command executes.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_r <= {WIDTH{1'b0}};
            res_cout_r <= 1'b0;
            res_zero_r <= 1'b0;
            acc_r      <= {WIDTH{1'b0}};
        end else if (state_r == ST_EXEC) begin
            res_data_r <= alu_o;
            res_cout_r <= carry_for_op(alu_op_r, alu_cout);
            res_zero_r <= is_zero(alu_o);
            acc_r      <= alu_o;
        end else begin
            res_data_r <= res_data_r;
            res_cout_r <= res_cout_r;
            res_zero_r <= res_zero_r;
            acc_r      <= acc_r;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_cout  = res_cout_r;
    assign bus.res_zero  = res_zero_r;
    assign alu_op        = alu_op_r;
    assign alu_i0        = alu_i0_r;
    assign alu_i1        = alu_i1_r;
    assign acc_q         = acc_r;

endmodule
